// File: rtl/fdct_block_feeder.sv
// rtl/fdct_block_feeder.sv - ping-pong 8x8 pixel block buffer and row sequencer for the FDCT front end
//
// Purpose: collects N rows of N pixels into one of two banks. Each full bank is
// replayed row by row toward level_shift, tagged with the row index and block
// sequence number. While one bank drains, the other bank fills.
//
// Ports:
//   clk, nrst        rising-edge clock, asynchronous active-low reset
//   in_row/in_valid  one pixel row per beat from upstream ([0] = leftmost pixel)
//   in_ready         high while the bank being written still has room
//   out_row/out_valid/out_ready  row stream to level_shift
//   out_row_idx      row number of out_row within its block
//   out_last         high on the final row of a block
//   out_blk_cnt      sequence number of the block being emitted (wraps)
//   bank_full        per-bank full flags
module fdct_block_feeder #(
  parameter int DATA_W    = 8,
  parameter int N         = 8,
  parameter int BLK_CNT_W = 16,
  localparam int ROW_W    = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [N-1:0][DATA_W-1:0]    in_row,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N-1:0][DATA_W-1:0]    out_row,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_W-1:0]            out_row_idx,
  output logic                        out_last,
  output logic [BLK_CNT_W-1:0]        out_blk_cnt,
  output logic [1:0]                  bank_full
);

  typedef enum logic {S_IDLE, S_SEND} state_e;
  typedef logic [N-1:0][DATA_W-1:0] row_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  state_e               state_q, state_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [ROW_W-1:0]     wr_row_q, wr_row_d;
  logic [ROW_W-1:0]     rd_row_q, rd_row_d;
  logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0]           bank_full_q, bank_full_d;
  row_t                 mem_q [2][N];
  row_t                 mem_d [2][N];

  logic wr_fire;
  logic rd_fire;

  assign in_ready    = !bank_full_q[wr_bank_q];
  assign wr_fire     = in_valid && in_ready;
  assign out_valid   = (state_q == S_SEND);
  assign rd_fire     = out_valid && out_ready;
  // Pixel storage has no reset, so the row is masked until a block is being sent.
  assign out_row     = out_valid ? mem_q[rd_bank_q][rd_row_q] : '0;
  assign out_row_idx = rd_row_q;
  assign out_last    = (rd_row_q == LAST_ROW);
  assign out_blk_cnt = blk_cnt_q;
  assign bank_full   = bank_full_q;

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[wr_bank_q][wr_row_q] = in_row;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_row_d    = wr_row_q;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
    blk_cnt_d   = blk_cnt_q;
    bank_full_d = bank_full_q;

    // A write only targets a non-full bank and a drain only clears a full bank,
    // so the set and clear below never hit the same flag in one cycle.
    if (wr_fire) begin
      if (wr_row_q == LAST_ROW) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_row_d               = '0;
      end else begin
        wr_row_d = wr_row_q + ROW_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = S_SEND;
          rd_row_d = '0;
        end
      end
      S_SEND: begin
        if (rd_fire) begin
          if (rd_row_q == LAST_ROW) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_row_d               = '0;
            blk_cnt_d              = blk_cnt_q + BLK_CNT_W'(1);
            // Continue straight into the other bank when it is already waiting.
            state_d = bank_full_q[~rd_bank_q] ? S_SEND : S_IDLE;
          end else begin
            rd_row_d = rd_row_q + ROW_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_row_q    <= '0;
      blk_cnt_q   <= '0;
      bank_full_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      rd_row_q    <= rd_row_d;
      blk_cnt_q   <= blk_cnt_d;
      bank_full_q <= bank_full_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fdct_block_feeder.sv
// tb/tb_fdct_block_feeder.sv - self-checking bench for fdct_block_feeder
module tb_fdct_block_feeder;
  localparam int N  = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic nrst;
  logic [N-1:0][DW-1:0] in_row;
  logic in_valid, out_ready;
  logic in_ready, out_valid, out_last;
  logic [N-1:0][DW-1:0] out_row;
  logic [2:0] out_row_idx;
  logic [15:0] out_blk_cnt;
  logic [1:0] bank_full;
  logic in_ready_w, out_valid_w, out_last_w;
  logic [N-1:0][DW-1:0] out_row_w;
  logic [2:0] out_row_idx_w;
  logic [1:0] out_blk_cnt_w;
  logic [1:0] bank_full_w;

  fdct_block_feeder #(.DATA_W(DW), .N(N), .BLK_CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .in_row(in_row), .in_valid(in_valid), .in_ready(in_ready),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
    .out_last(out_last), .out_blk_cnt(out_blk_cnt), .bank_full(bank_full));

  fdct_block_feeder #(.DATA_W(DW), .N(N), .BLK_CNT_W(2)) dut_w (
    .clk(clk), .nrst(nrst), .in_row(in_row), .in_valid(in_valid), .in_ready(in_ready_w),
    .out_row(out_row_w), .out_valid(out_valid_w), .out_ready(out_ready), .out_row_idx(out_row_idx_w),
    .out_last(out_last_w), .out_blk_cnt(out_blk_cnt_w), .bank_full(bank_full_w));

  always #5 clk = ~clk;

  typedef struct { logic [63:0] row; int blk; int idx; } exp_t;
  typedef struct { logic [63:0] row; int idx; logic last; int blk; int blk2; int cyc; } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cnt = 0, last_acc_cyc = -1, hold_err = 0, twin_err = 0;
  bit prev_stall = 1'b0;
  logic [63:0] prev_row;
  logic [2:0] prev_idx;
  logic [15:0] prev_blk;
  logic prev_last;

  always @(posedge clk) cyc++;

  // Reference model: every accepted row is owed back once, in order, tagged
  // with (accepted rows / N) as block number and (accepted rows % N) as row index.
  always @(negedge clk) begin
    if (nrst) begin
      exp_t e;
      got_t g;
      if (in_valid && in_ready) begin
        e.row = in_row; e.blk = acc_cnt / N; e.idx = acc_cnt % N;
        exp_q.push_back(e);
        if (acc_cnt % N == N - 1) last_acc_cyc = cyc;
        acc_cnt++;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_row !== prev_row || out_row_idx !== prev_idx ||
                         out_blk_cnt !== prev_blk || out_last !== prev_last))
        hold_err++;
      if (out_valid_w !== out_valid || out_row_w !== out_row || in_ready_w !== in_ready ||
          bank_full_w !== bank_full || out_row_idx_w !== out_row_idx || out_last_w !== out_last)
        twin_err++;
      if (out_valid && out_ready) begin
        g.row = out_row; g.idx = int'(out_row_idx); g.last = out_last;
        g.blk = int'(out_blk_cnt); g.blk2 = int'(out_blk_cnt_w); g.cyc = cyc;
        got_q.push_back(g);
      end
      prev_stall = out_valid && !out_ready;
      prev_row = out_row; prev_idx = out_row_idx; prev_blk = out_blk_cnt; prev_last = out_last;
    end
  end

  function automatic logic [63:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_model();
    exp_q.delete(); got_q.delete();
    acc_cnt = 0; prev_stall = 1'b0; last_acc_cyc = -1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic send_row(input logic [63:0] r);
    int k = 0;
    in_row = r; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 3000) begin @(negedge clk); k++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_row_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (got_q.size() < n && k < 4000) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL beat_count_timeout got=%0d required=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    n_checks += 7;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b req=0", out_valid); end
    if (out_row !== '0) begin n_fail++; $display("FAIL rst_out_row got=%h req=0", out_row); end
    if (out_row_idx !== 3'd0) begin n_fail++; $display("FAIL rst_row_idx got=%0d req=0", out_row_idx); end
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got=%b req=0", out_last); end
    if (out_blk_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_blk_cnt got=%0d req=0", out_blk_cnt); end
    if (bank_full !== 2'b00) begin n_fail++; $display("FAIL rst_bank_full got=%b req=00", bank_full); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b req=1", in_ready); end
    // One block drained, then a full bank plus a partial fill, then reset mid-cycle.
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(rand_row());
    in_valid = 1'b0;
    wait_beats(N);
    out_ready = 1'b0;
    for (int r = 0; r < N + 3; r++) send_row(rand_row());
    in_valid = 1'b0;
    #3 nrst = 1'b0;
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got=%b req=0", out_valid); end
    if (out_row !== '0) begin n_fail++; $display("FAIL arst_out_row got=%h req=0", out_row); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got=%b req=1", in_ready); end
    if (bank_full !== 2'b00) begin n_fail++; $display("FAIL arst_bank_full got=%b req=00", bank_full); end
    if (out_blk_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_blk_cnt got=%0d req=0", out_blk_cnt); end
    clear_model();
    @(posedge clk); @(posedge clk); #1 nrst = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(rand_row());
    in_valid = 1'b0;
    wait_beats(N);
    n_checks += 2;
    if (got_q.size() !== N || got_q[0].blk !== 0) begin
      n_fail++; $display("FAIL after_reset_blk got=%0d req=0", got_q.size() > 0 ? got_q[0].blk : -1);
    end
    if (got_q.size() !== N || got_q[0].row !== exp_q[0].row) begin
      n_fail++; $display("FAIL after_reset_row got=%h req=%h", got_q[0].row, exp_q[0].row);
    end
  endtask

  task automatic test_single();
    logic [63:0] r_v;
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int i = 0; i < N; i++) r_v[i*8 +: 8] = 8'(8 * r + i);
      send_row(r_v);
    end
    in_valid = 1'b0;
    wait_beats(N);
    n_checks++;
    if (got_q.size() !== N || got_q[0].cyc !== last_acc_cyc + 2) begin
      n_fail++; $display("FAIL single_latency got=%0d req=%0d", got_q[0].cyc - last_acc_cyc, 2);
    end
    for (int r = 0; r < N && r < got_q.size(); r++) begin
      for (int i = 0; i < N; i++) r_v[i*8 +: 8] = 8'(8 * r + i);
      n_checks++;
      if (got_q[r].row !== r_v || got_q[r].idx !== r || got_q[r].last !== (r == N - 1) ||
          got_q[r].blk !== 0 || got_q[r].cyc !== got_q[0].cyc + r) begin
        n_fail++;
        $display("FAIL single_beat%0d row=%h idx=%0d last=%b blk=%0d cyc=%0d req row=%h idx=%0d last=%b blk=0 cyc=%0d",
                 r, got_q[r].row, got_q[r].idx, got_q[r].last, got_q[r].blk, got_q[r].cyc,
                 r_v, r, (r == N - 1), got_q[0].cyc + r);
      end
    end
  endtask

  task automatic test_continuous();
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 4 * N; r++) send_row(rand_row());
    in_valid = 1'b0;
    wait_beats(4 * N);
    n_checks++;
    if (got_q.size() !== 4 * N) begin n_fail++; $display("FAIL cont_count got=%0d req=%0d", got_q.size(), 4 * N); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].row !== exp_q[i].row || got_q[i].idx !== exp_q[i].idx ||
          got_q[i].last !== (exp_q[i].idx == N - 1) || got_q[i].blk !== exp_q[i].blk ||
          got_q[i].cyc !== got_q[i - exp_q[i].idx].cyc + exp_q[i].idx) begin
        n_fail++;
        $display("FAIL cont_beat%0d row=%h idx=%0d blk=%0d req row=%h idx=%0d blk=%0d",
                 i, got_q[i].row, got_q[i].idx, got_q[i].blk, exp_q[i].row, exp_q[i].idx, exp_q[i].blk);
      end
    end
  endtask

  task automatic test_backpressure();
    int f8 = -1, rise = -1, k = 0;
    do_reset();
    for (int r = 0; r < 2 * N; r++) send_row(rand_row());
    in_row = rand_row(); in_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    n_checks += 5;
    if (bank_full !== 2'b11) begin n_fail++; $display("FAIL bp_bank_full got=%b req=11", bank_full); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b req=0", in_ready); end
    if (exp_q.size() !== 2 * N) begin n_fail++; $display("FAIL bp_held_row accepted=%0d req=%0d", exp_q.size(), 2 * N); end
    if (out_valid !== 1'b1 || out_row_idx !== 3'd0) begin
      n_fail++; $display("FAIL bp_out_stalled valid=%b idx=%0d req valid=1 idx=0", out_valid, out_row_idx);
    end
    if (out_row !== exp_q[0].row) begin n_fail++; $display("FAIL bp_out_row got=%h req=%h", out_row, exp_q[0].row); end
    @(posedge clk); #1 out_ready = 1'b1;
    while (rise < 0 && k < 100) begin
      @(negedge clk); #1;
      if (got_q.size() >= N && f8 < 0) f8 = got_q[N - 1].cyc;
      if (in_ready && rise < 0) rise = cyc;
      k++;
    end
    n_checks++;
    if (f8 < 0 || rise !== f8 + 1) begin n_fail++; $display("FAIL bp_ready_rise got=%0d req=%0d", rise, f8 + 1); end
    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() !== 2 * N + 1) begin n_fail++; $display("FAIL bp_17th_accept got=%0d req=%0d", exp_q.size(), 2 * N + 1); end
    for (int r = 0; r < N - 1; r++) send_row(rand_row());
    in_valid = 1'b0;
    wait_beats(3 * N);
    n_checks++;
    if (got_q[N].cyc !== got_q[N - 1].cyc + 1) begin
      n_fail++; $display("FAIL bp_no_bubble gap=%0d req=1", got_q[N].cyc - got_q[N - 1].cyc);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].row !== exp_q[i].row || got_q[i].idx !== exp_q[i].idx || got_q[i].blk !== exp_q[i].blk) begin
        n_fail++;
        $display("FAIL bp_beat%0d row=%h idx=%0d blk=%0d req row=%h idx=%0d blk=%0d",
                 i, got_q[i].row, got_q[i].idx, got_q[i].blk, exp_q[i].row, exp_q[i].idx, exp_q[i].blk);
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    hold_err = 0;
    fork
      begin
        for (int r = 0; r < 64 * N; r++) send_row(rand_row());
        in_valid = 1'b0;
      end
      begin
        int k = 0;
        while (got_q.size() < 64 * N && k < 8000) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
          k++;
        end
      end
    join
    wait_beats(64 * N);
    n_checks += 2;
    if (hold_err !== 0) begin n_fail++; $display("FAIL stall_hold violations=%0d req=0", hold_err); end
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].row !== exp_q[i].row || got_q[i].idx !== exp_q[i].idx ||
          got_q[i].last !== (exp_q[i].idx == N - 1) || got_q[i].blk !== exp_q[i].blk % 65536 ||
          got_q[i].blk2 !== exp_q[i].blk % 4) begin
        n_fail++;
        $display("FAIL stall_beat%0d row=%h idx=%0d blk=%0d blk2=%0d req row=%h idx=%0d blk=%0d",
                 i, got_q[i].row, got_q[i].idx, got_q[i].blk, got_q[i].blk2, exp_q[i].row, exp_q[i].idx, exp_q[i].blk);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_w[5] = '{0, 1, 2, 3, 0};
    do_reset();
    twin_err = 0;
    out_ready = 1'b1;
    for (int r = 0; r < 5 * N; r++) send_row(rand_row());
    in_valid = 1'b0;
    wait_beats(5 * N);
    for (int b = 0; b < 5 && b * N < got_q.size(); b++) begin
      n_checks += 2;
      if (got_q[b * N].blk2 !== exp_w[b]) begin
        n_fail++; $display("FAIL wrap_blk%0d got=%0d req=%0d", b, got_q[b * N].blk2, exp_w[b]);
      end
      if (got_q[b * N].blk !== b) begin
        n_fail++; $display("FAIL wide_blk%0d got=%0d req=%0d", b, got_q[b * N].blk, b);
      end
    end
    n_checks++;
    if (twin_err !== 0) begin n_fail++; $display("FAIL wrap_other_outputs diffs=%0d req=0", twin_err); end
  endtask

  initial begin
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    test_reset();
    test_single();
    test_continuous();
    test_backpressure();
    test_stall_hold();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
